// File: rtl/mem_responder_pkg.sv
// Shared types and geometry for the memory responder.
package mem_responder_pkg;

  localparam int unsigned BEATS  = 4;
  localparam int unsigned BEAT_W = 64;
  localparam int unsigned LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITEBACK,
    RESP
  } state_e;

endpackage

// File: rtl/mem_responder_if.sv
// CPU-side request/response and backing-memory burst signals.
interface mem_responder_if;

  logic [31:0] cpu_address;
  logic [3:0]  cpu_rmask;
  logic [3:0]  cpu_wmask;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_resp;
  logic [31:0] bmem_address;
  logic        bmem_read;
  logic        bmem_write;
  logic [63:0] bmem_wdata;
  logic [63:0] bmem_rdata;
  logic        bmem_resp;

  // Responder view
  modport slave (
    input  cpu_address, cpu_rmask, cpu_wmask, cpu_wdata, bmem_rdata, bmem_resp,
    output cpu_rdata, cpu_resp, bmem_address, bmem_read, bmem_write, bmem_wdata
  );

  // Requester / memory-model view
  modport master (
    output cpu_address, cpu_rmask, cpu_wmask, cpu_wdata, bmem_rdata, bmem_resp,
    input  cpu_rdata, cpu_resp, bmem_address, bmem_read, bmem_write, bmem_wdata
  );

endinterface

// File: rtl/mem_responder_line_buffer.sv
// Single-line buffer: valid/tag, beat-wise fill and byte-lane store merge.
module line_buffer #(
  parameter int unsigned BEATS  = 4,
  parameter int unsigned BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              beat_we_i,
  input  logic [1:0]        beat_idx_i,
  input  logic [BEAT_W-1:0] beat_data_i,
  input  logic              set_valid_i,
  input  logic [26:0]       tag_i,
  input  logic              merge_i,
  input  logic [2:0]        word_idx_i,
  input  logic [3:0]        wmask_i,
  input  logic [31:0]       wdata_i,
  output logic              valid_o,
  output logic [26:0]       tag_o,
  output logic [31:0]       word_o,
  output logic [BEAT_W-1:0] beat_o
);

  localparam int unsigned LW = BEATS * BEAT_W;
  localparam int unsigned IW = $clog2(LW);

  logic [LW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic [26:0]   tag_q, tag_d;
  logic [IW-1:0] word_lsb, beat_lsb;

  assign word_lsb = IW'({word_idx_i, 5'b00000});
  assign beat_lsb = IW'(beat_idx_i) * IW'(BEAT_W);

  // Beat write lands first so a merge on the final fill beat overrides it
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q | set_valid_i;
    tag_d   = set_valid_i ? tag_i : tag_q;
    if (beat_we_i) begin
      data_d[beat_lsb +: BEAT_W] = beat_data_i;
    end
    if (merge_i) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wmask_i[b]) begin
          data_d[word_lsb + IW'(8 * b) +: 8] = wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Buffer state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      tag_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
    end
  end

  assign valid_o = valid_q;
  assign tag_o   = tag_q;
  assign word_o  = data_q[word_lsb +: 32];
  assign beat_o  = data_q[beat_lsb +: BEAT_W];

endmodule

// File: rtl/mem_responder.sv
// Write-through single-line responder between a CPU memory stage and a
// 4-beat burst backing memory.
module mem_responder #(
  parameter int unsigned BEATS  = mem_responder_pkg::BEATS,
  parameter int unsigned BEAT_W = mem_responder_pkg::BEAT_W
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  import mem_responder_pkg::*;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              is_write, is_req, hit, last_beat;
  logic              beat_we, set_valid, merge;
  logic              buf_valid;
  logic [26:0]       buf_tag;
  logic [31:0]       buf_word;
  logic [BEAT_W-1:0] buf_beat;
  logic [31:0]       line_addr;

  assign is_write  = |bus.cpu_wmask;
  assign is_req    = is_write | (|bus.cpu_rmask);
  assign hit       = buf_valid && (buf_tag == bus.cpu_address[31:5]);
  assign last_beat = bus.bmem_resp && (cnt_q == 2'(BEATS - 1));
  assign line_addr = {bus.cpu_address[31:5], 5'b00000};

  line_buffer #(
    .BEATS  (BEATS),
    .BEAT_W (BEAT_W)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst),
    .beat_we_i   (beat_we),
    .beat_idx_i  (cnt_q),
    .beat_data_i (bus.bmem_rdata),
    .set_valid_i (set_valid),
    .tag_i       (bus.cpu_address[31:5]),
    .merge_i     (merge),
    .word_idx_i  (bus.cpu_address[4:2]),
    .wmask_i     (bus.cpu_wmask),
    .wdata_i     (bus.cpu_wdata),
    .valid_o     (buf_valid),
    .tag_o       (buf_tag),
    .word_o      (buf_word),
    .beat_o      (buf_beat)
  );

  // State and beat counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, buffer controls and bus outputs; outputs are zero outside
  // their active states so reset clears them immediately
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    beat_we          = 1'b0;
    set_valid        = 1'b0;
    merge            = 1'b0;
    bus.cpu_resp     = 1'b0;
    bus.cpu_rdata    = '0;
    bus.bmem_address = '0;
    bus.bmem_read    = 1'b0;
    bus.bmem_write   = 1'b0;
    bus.bmem_wdata   = '0;
    unique case (state_q)
      IDLE: begin
        if (is_req) begin
          if (!hit) begin
            state_d = FILL;
            cnt_d   = '0;
          end else if (is_write) begin
            merge   = 1'b1;
            state_d = WRITEBACK;
            cnt_d   = '0;
          end else begin
            state_d = RESP;
          end
        end
      end
      FILL: begin
        bus.bmem_read    = 1'b1;
        bus.bmem_address = line_addr;
        if (bus.bmem_resp) begin
          beat_we = 1'b1;
          cnt_d   = cnt_q + 2'd1;
        end
        if (last_beat) begin
          set_valid = 1'b1;
          if (is_write) begin
            merge   = 1'b1;
            state_d = WRITEBACK;
            cnt_d   = '0;
          end else begin
            state_d = RESP;
          end
        end
      end
      WRITEBACK: begin
        bus.bmem_write   = 1'b1;
        bus.bmem_address = line_addr;
        bus.bmem_wdata   = buf_beat;
        if (bus.bmem_resp) begin
          cnt_d = cnt_q + 2'd1;
        end
        if (last_beat) begin
          state_d = RESP;
        end
      end
      RESP: begin
        bus.cpu_resp  = 1'b1;
        bus.cpu_rdata = buf_word;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: burst memory model with random stalls plus a
// line-level reference model of the responder's buffer.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_responder_if bus ();

  mem_responder #(
    .BEATS  (4),
    .BEAT_W (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Backing memory, keyed by beat byte address
  logic [63:0] mem [logic [31:0]];

  // Memory-side bookkeeping
  int          ncyc = 0;
  int          rd_beats = 0;
  int          wr_beats = 0;
  int          last_acc = -1;
  int          beat = 0;
  int          stall = 0;
  bit          active = 0;
  bit          resp_q = 0;
  bit          resp_is_wr = 0;
  bit          prev_cpu_resp = 0;
  logic [31:0] burst_addr = '0;
  logic [63:0] drv_wdata = '0;
  logic [63:0] wb_q [$];

  // Reference model of the line buffer
  bit          ref_valid = 0;
  logic [26:0] ref_tag = '0;
  logic [31:0] ref_line [8];
  logic [63:0] exp_beats [4];

  function automatic logic [63:0] mem_beat(input logic [31:0] line, input int b);
    logic [31:0] key;
    key = line + 32'(8 * b);
    if (!mem.exists(key)) mem[key] = {$urandom, $urandom};
    return mem[key];
  endfunction

  // Burst memory with 0-5 cycle stalls per beat, plus protocol monitors
  always @(negedge clk) begin
    ncyc++;
    if (!rst) begin
      active = 0;
      resp_q = 0;
      bus.bmem_resp = 1'b0;
      prev_cpu_resp = 0;
    end else begin
      checks++;
      if (bus.bmem_read && bus.bmem_write) begin
        errors++;
        $display("FAIL rw_overlap: bmem_read=%0b bmem_write=%0b, required not both 1", bus.bmem_read, bus.bmem_write);
      end
      checks++;
      if (prev_cpu_resp && bus.cpu_resp) begin
        errors++;
        $display("FAIL resp_width: cpu_resp high 2 cycles, required 1");
      end
      prev_cpu_resp = bus.cpu_resp;
      if (resp_q) begin
        last_acc = ncyc;
        if (resp_is_wr) begin
          wr_beats++;
          wb_q.push_back(drv_wdata);
        end else begin
          rd_beats++;
        end
        beat++;
        if (beat == 4) active = 0;
      end
      resp_q = 0;
      bus.bmem_resp = 1'b0;
      if (!active && (bus.bmem_read || bus.bmem_write)) begin
        active = 1;
        beat = 0;
        stall = $urandom_range(0, 5);
      end
      if (active && (bus.bmem_read || bus.bmem_write)) begin
        if (stall > 0) begin
          stall--;
        end else begin
          resp_q = 1;
          bus.bmem_resp = 1'b1;
          resp_is_wr = bus.bmem_write;
          burst_addr = bus.bmem_address;
          drv_wdata = bus.bmem_wdata;
          bus.bmem_rdata = bus.bmem_write ? 64'h0 : mem_beat(bus.bmem_address, beat);
          stall = $urandom_range(0, 5);
        end
      end
    end
  end

  // Predicts one access at line level; memory is committed separately after
  // the DUT finishes so fills always see the pre-store contents
  task automatic model_access(input logic [31:0] addr, input logic [3:0] wm, input logic [31:0] wd,
                              output bit exp_fill, output bit exp_wb, output logic [31:0] exp_rdata);
    logic [31:0] line;
    logic [63:0] b;
    int          w;
    line = {addr[31:5], 5'b0};
    w = int'(addr[4:2]);
    exp_fill = !(ref_valid && ref_tag == addr[31:5]);
    if (exp_fill) begin
      for (int i = 0; i < 8; i++) begin
        b = mem_beat(line, i / 2);
        ref_line[i] = (i % 2 == 1) ? b[63:32] : b[31:0];
      end
      ref_valid = 1;
      ref_tag = addr[31:5];
    end
    exp_wb = (wm != 4'b0);
    if (exp_wb) begin
      for (int k = 0; k < 4; k++)
        if (wm[k]) ref_line[w][8*k +: 8] = wd[8*k +: 8];
      for (int k = 0; k < 4; k++) exp_beats[k] = {ref_line[2*k+1], ref_line[2*k]};
    end
    exp_rdata = ref_line[w];
  endtask

  task automatic mem_commit(input logic [31:0] addr);
    for (int k = 0; k < 4; k++) mem[{addr[31:5], 5'b0} + 32'(8 * k)] = exp_beats[k];
  endtask

  // Drives one request from an IDLE cycle and waits (bounded) for cpu_resp
  task automatic do_req(input logic [31:0] addr, input logic [3:0] rm, input logic [3:0] wm,
                        input logic [31:0] wd, output bit got, output logic [31:0] rdata,
                        output int lat, output int acc_gap, output int nrd, output int nwr);
    int rd0, wr0, t0;
    @(negedge clk);
    #1;
    wb_q.delete();
    rd0 = rd_beats;
    wr0 = wr_beats;
    t0 = ncyc;
    bus.cpu_address = addr;
    bus.cpu_rmask = rm;
    bus.cpu_wmask = wm;
    bus.cpu_wdata = wd;
    got = 0;
    rdata = '0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      #1;
      if (bus.cpu_resp) begin
        got = 1;
        rdata = bus.cpu_rdata;
      end
    end
    lat = ncyc - t0;
    acc_gap = ncyc - last_acc;
    nrd = rd_beats - rd0;
    nwr = wr_beats - wr0;
    bus.cpu_rmask = '0;
    bus.cpu_wmask = '0;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.cpu_resp !== 1'b0) begin errors++; $display("FAIL rst_cpu_resp: got %0b want 0", bus.cpu_resp); end
    checks++;
    if (bus.cpu_rdata !== 32'h0) begin errors++; $display("FAIL rst_cpu_rdata: got %h want 0", bus.cpu_rdata); end
    checks++;
    if (bus.bmem_read !== 1'b0 || bus.bmem_write !== 1'b0) begin
      errors++; $display("FAIL rst_bmem_rw: got r=%0b w=%0b want 0 0", bus.bmem_read, bus.bmem_write);
    end
    checks++;
    if (bus.bmem_wdata !== 64'h0) begin errors++; $display("FAIL rst_bmem_wdata: got %h want 0", bus.bmem_wdata); end
    checks++;
    if (bus.bmem_address !== 32'h0) begin errors++; $display("FAIL rst_bmem_address: got %h want 0", bus.bmem_address); end
  endtask

  task automatic test_read_miss();
    bit got, ef, ew;
    logic [31:0] rd, er;
    int lat, gap, nrd, nwr;
    mem[32'h4000_0020] = 64'h1111_1111_1111_1111;
    mem[32'h4000_0028] = 64'h2222_2222_2222_2222;
    mem[32'h4000_0030] = 64'h3333_3333_3333_3333;
    mem[32'h4000_0038] = 64'h4444_4444_4444_4444;
    model_access(32'h4000_0024, 4'b0, 32'h0, ef, ew, er);
    do_req(32'h4000_0024, 4'b1111, 4'b0, 32'h0, got, rd, lat, gap, nrd, nwr);
    checks++;
    if (!got) begin errors++; $display("FAIL miss_resp: no cpu_resp within bound"); end
    checks++;
    if (rd !== 32'h1111_1111 || rd !== er) begin errors++; $display("FAIL miss_rdata: got %h want %h", rd, er); end
    checks++;
    if (nrd != 4 || nwr != 0) begin errors++; $display("FAIL miss_beats: got rd=%0d wr=%0d want 4 0", nrd, nwr); end
    checks++;
    if (burst_addr !== 32'h4000_0020) begin errors++; $display("FAIL miss_addr: got %h want 40000020", burst_addr); end
    checks++;
    if (gap != 0) begin errors++; $display("FAIL miss_latency: resp %0d cycles after last beat, want 1", gap + 1); end
  endtask

  task automatic test_read_hit();
    bit got, ef, ew;
    logic [31:0] rd, er;
    int lat, gap, nrd, nwr;
    model_access(32'h4000_0038, 4'b0, 32'h0, ef, ew, er);
    do_req(32'h4000_0038, 4'b0011, 4'b0, 32'h0, got, rd, lat, gap, nrd, nwr);
    checks++;
    if (!got || rd !== 32'h4444_4444 || rd !== er) begin
      errors++; $display("FAIL hit_rdata: got %h (resp=%0b) want %h", rd, got, er);
    end
    checks++;
    if (lat != 1) begin errors++; $display("FAIL hit_latency: got %0d want 1", lat); end
    checks++;
    if (nrd != 0 || nwr != 0) begin errors++; $display("FAIL hit_bmem: got rd=%0d wr=%0d want 0 0", nrd, nwr); end
  endtask

  task automatic test_write_hit_byte();
    bit got, ef, ew;
    logic [31:0] rd, er;
    int lat, gap, nrd, nwr;
    model_access(32'h4000_0021, 4'b0010, 32'h0000_AB00, ef, ew, er);
    do_req(32'h4000_0021, 4'b0000, 4'b0010, 32'h0000_AB00, got, rd, lat, gap, nrd, nwr);
    mem_commit(32'h4000_0021);
    checks++;
    if (!got) begin errors++; $display("FAIL sb_resp: no cpu_resp within bound"); end
    checks++;
    if (nrd != 0 || nwr != 4) begin errors++; $display("FAIL sb_beats: got rd=%0d wr=%0d want 0 4", nrd, nwr); end
    if (wb_q.size() == 4) begin
      checks++;
      if (wb_q[0] !== 64'h1111_1111_1111_AB11) begin errors++; $display("FAIL sb_beat0: got %h want 111111111111ab11", wb_q[0]); end
      for (int k = 1; k < 4; k++) begin
        checks++;
        if (wb_q[k] !== exp_beats[k]) begin errors++; $display("FAIL sb_beat%0d: got %h want %h", k, wb_q[k], exp_beats[k]); end
      end
    end
    checks++;
    if (gap != 0 || rd !== er) begin errors++; $display("FAIL sb_done: gap=%0d rdata=%h want gap 0 rdata %h", gap, rd, er); end
  endtask

  task automatic test_write_miss();
    bit got, ef, ew;
    logic [31:0] rd, er, wd;
    int lat, gap, nrd, nwr, extra;
    wd = $urandom;
    model_access(32'h4000_1000, 4'b1111, wd, ef, ew, er);
    do_req(32'h4000_1000, 4'b0000, 4'b1111, wd, got, rd, lat, gap, nrd, nwr);
    mem_commit(32'h4000_1000);
    checks++;
    if (!got || nrd != 4 || nwr != 4) begin
      errors++; $display("FAIL sw_miss_beats: resp=%0b rd=%0d wr=%0d want 1 4 4", got, nrd, nwr);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= wb_q.size() || wb_q[k] !== exp_beats[k]) begin
        errors++; $display("FAIL sw_miss_beat%0d: got %h want %h", k, (k < wb_q.size()) ? wb_q[k] : 64'hx, exp_beats[k]);
      end
    end
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (bus.cpu_resp) extra++;
    end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL sw_miss_single_resp: got %0d extra pulses want 0", extra); end
  endtask

  task automatic test_reset_mid_fill();
    bit got, ef, ew, reached;
    logic [31:0] rd, er;
    int lat, gap, nrd, nwr, rd0;
    @(negedge clk);
    #1;
    rd0 = rd_beats;
    bus.cpu_address = 32'h4000_2008;
    bus.cpu_rmask = 4'b1111;
    bus.cpu_wmask = 4'b0;
    reached = 0;
    for (int i = 0; i < 200 && !reached; i++) begin
      @(negedge clk);
      #1;
      if (rd_beats - rd0 >= 2) reached = 1;
    end
    checks++;
    if (!reached) begin errors++; $display("FAIL rst_fill_progress: 2 beats not reached within bound"); end
    rst = 1'b0;
    bus.cpu_rmask = 4'b0;
    #1;
    checks++;
    if (bus.bmem_read !== 1'b0 || bus.bmem_address !== 32'h0) begin
      errors++; $display("FAIL rst_mid_fill: bmem_read=%0b addr=%h want 0 0", bus.bmem_read, bus.bmem_address);
    end
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    ref_valid = 0;
    model_access(32'h4000_2008, 4'b0, 32'h0, ef, ew, er);
    do_req(32'h4000_2008, 4'b1111, 4'b0, 32'h0, got, rd, lat, gap, nrd, nwr);
    checks++;
    if (!got || nrd != 4 || rd !== er) begin
      errors++; $display("FAIL refetch: resp=%0b rd=%0d rdata=%h want 1 4 %h", got, nrd, rd, er);
    end
  endtask

  task automatic test_random();
    bit got, ef, ew;
    logic [31:0] addr, rd, er, wd;
    logic [3:0] rm, wm;
    int lat, gap, nrd, nwr;
    for (int t = 0; t < 60; t++) begin
      addr = 32'h5000_0000 | (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      wd = $urandom;
      rm = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) wm = 4'($urandom_range(1, 15));
      else begin wm = 4'b0; if (rm == 4'b0) rm = 4'b1111; end
      model_access(addr, wm, wd, ef, ew, er);
      do_req(addr, rm, wm, wd, got, rd, lat, gap, nrd, nwr);
      if (ew) mem_commit(addr);
      checks++;
      if (!got || rd !== er) begin errors++; $display("FAIL rnd%0d_rdata: addr=%h got %h want %h", t, addr, rd, er); end
      checks++;
      if (nrd != (ef ? 4 : 0) || nwr != (ew ? 4 : 0)) begin
        errors++; $display("FAIL rnd%0d_beats: got rd=%0d wr=%0d want %0d %0d", t, nrd, nwr, ef ? 4 : 0, ew ? 4 : 0);
      end
      checks++;
      if ((!ef && !ew) ? (lat != 1) : (gap != 0)) begin
        errors++; $display("FAIL rnd%0d_latency: lat=%0d gap=%0d", t, lat, gap);
      end
      if (ew && wb_q.size() == 4) begin
        for (int k = 0; k < 4; k++) begin
          checks++;
          if (wb_q[k] !== exp_beats[k]) begin errors++; $display("FAIL rnd%0d_wb%0d: got %h want %h", t, k, wb_q[k], exp_beats[k]); end
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    bus.cpu_address = '0;
    bus.cpu_rmask = '0;
    bus.cpu_wmask = '0;
    bus.cpu_wdata = '0;
    bus.bmem_rdata = '0;
    bus.bmem_resp = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    test_reset();
    rst = 1'b1;
    test_read_miss();
    test_read_hit();
    test_write_hit_byte();
    test_write_miss();
    test_reset_mid_fill();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
